// File: rtl/cq_pair_packer.sv
`timescale 1ns/1ps
// Drain stage for the circular queue: reads words, packs consecutive pairs into 2*DW beats.
// A held flush emits a lone leftover word as a half-filled beat so an odd tail never sticks.
module cq_pair_packer #(
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            q_empty,
    input  logic [DW-1:0]   q_dout,
    output logic            q_rd,
    input  logic            flush,
    output logic [2*DW-1:0] out_data,
    output logic            out_odd,
    output logic            out_valid,
    input  logic            out_ready
);

    logic          inflight;
    logic          have_lo;
    logic [DW-1:0] lo;
    logic [1:0]    occ;

    assign occ = {1'b0, have_lo} + {1'b0, inflight};

    // A read that completes a pair waits for an empty output register, so the capture always has a slot.
    assign q_rd = !reset && !q_empty && ((occ == 2'd0) || ((occ == 2'd1) && !out_valid));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight  <= 1'b0;
            have_lo   <= 1'b0;
            lo        <= '0;
            out_data  <= '0;
            out_odd   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            inflight <= q_rd;
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (inflight) begin
                if (!have_lo) begin
                    lo      <= q_dout;
                    have_lo <= 1'b1;
                end else begin
                    out_data  <= {q_dout, lo};
                    out_odd   <= 1'b0;
                    out_valid <= 1'b1;
                    have_lo   <= 1'b0;
                end
            end else if (flush && have_lo && !out_valid) begin
                // Flush only acts with nothing in flight, so it never races a capture.
                out_data  <= {{DW{1'b0}}, lo};
                out_odd   <= 1'b1;
                out_valid <= 1'b1;
                have_lo   <= 1'b0;
            end
        end
    end

endmodule
